// File: rtl/gtx_link_supervisor.sv
// gtx_link_supervisor
//   Brings up and recovers one GTX serial link. It pulses a request to the GTX
//   reset generator and waits for the generator's start indication. It then
//   qualifies PLL lock and RX alignment over a stable window. Timeouts and link
//   loss cause a bounded number of retries before the link is declared failed.
//
// Ports
//   clk          system clock
//   rst_in       synchronous active-high reset
//   force_reset  user re-initialise request, acts on its rising edge
//   gt_start     start indication from the GTX reset generator (clk domain)
//   pll_lock     GTX PLL lock (asynchronous, 2-flop synchronised here)
//   rx_aligned   RX alignment (asynchronous, 2-flop synchronised here)
//   rst_request  registered request to the GTX reset generator
//   link_up      link qualified and up
//   link_fail    retries exhausted; held until force_reset edge or rst_in
//   retry_cnt    retries since the last UP or force_reset
//   state        FSM state: IDLE=0 REQ=1 WAIT_START=2 WAIT_LINK=3 UP=4 FAIL=5
module gtx_link_supervisor #(
  parameter int unsigned REQ_CYCLES    = 16,
  parameter int unsigned START_TIMEOUT = 200000000,
  parameter int unsigned LINK_TIMEOUT  = 10000000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 7
) (
  input  logic       clk,
  input  logic       rst_in,
  input  logic       force_reset,
  input  logic       gt_start,
  input  logic       pll_lock,
  input  logic       rx_aligned,
  output logic       rst_request,
  output logic       link_up,
  output logic       link_fail,
  output logic [3:0] retry_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    REQ        = 3'd1,
    WAIT_START = 3'd2,
    WAIT_LINK  = 3'd3,
    UP         = 3'd4,
    FAIL       = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] stable_q, stable_d;
  logic [3:0]  retry_q, retry_d;
  logic        rst_request_q, link_up_q, link_fail_q;
  logic        force_prev_q, force_edge_q;
  logic        do_retry;
  logic        link_ok;

  // Two-flop synchronisers for the asynchronous status inputs.
  // Bit 0 is pll_lock and bit 1 is rx_aligned.
  logic [1:0] async_in;
  logic [1:0] meta_q;
  logic [1:0] sync_q;
  assign async_in = {rx_aligned, pll_lock};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    always_ff @(posedge clk) begin
      if (rst_in) begin
        meta_q[gi] <= 1'b0;
        sync_q[gi] <= 1'b0;
      end else begin
        meta_q[gi] <= async_in[gi];
        sync_q[gi] <= meta_q[gi];
      end
    end
  end

  assign link_ok = sync_q[0] & sync_q[1];

  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    do_retry = 1'b0;

    case (state_q)
      IDLE:       state_d = REQ;
      REQ:        if (timer_q == 32'(REQ_CYCLES - 1)) state_d = WAIT_START;
      WAIT_START: begin
        // A start indication on the timeout cycle still counts as success.
        if (gt_start)                                 state_d  = WAIT_LINK;
        else if (timer_q == 32'(START_TIMEOUT - 1))   do_retry = 1'b1;
      end
      WAIT_LINK: begin
        // gt_start was high on entry, so a low level here means it fell.
        // The stable counter reaches STABLE_CYCLES on the edge that moves to UP.
        if (!gt_start)                                do_retry = 1'b1;
        else if (link_ok && stable_q == 32'(STABLE_CYCLES - 1)) state_d = UP;
        else if (timer_q == 32'(LINK_TIMEOUT - 1))    do_retry = 1'b1;
      end
      UP:         if (!link_ok || !gt_start) do_retry = 1'b1;
      FAIL:       state_d = FAIL;
      default:    state_d = IDLE;
    endcase

    // The FAIL check uses equality, so retry_cnt cannot pass MAX_RETRIES.
    if (do_retry) begin
      if (retry_q == 4'(MAX_RETRIES)) begin
        state_d = FAIL;
      end else begin
        retry_d = retry_q + 4'd1;
        state_d = REQ;
      end
    end

    if (state_q != UP && state_d == UP) retry_d = 4'd0;

    // A force edge overrides everything except rst_in. It restarts REQ from
    // zero even if the FSM is already in REQ.
    if (force_edge_q) begin
      state_d = REQ;
      retry_d = 4'd0;
    end

    // The timer clears on every state entry, including a forced REQ re-entry.
    if (force_edge_q || state_d != state_q)
      timer_d = 32'd0;
    else if (state_q == REQ || state_q == WAIT_START || state_q == WAIT_LINK)
      timer_d = timer_q + 32'd1;
    else
      timer_d = 32'd0;

    stable_d = (state_q == WAIT_LINK && link_ok) ? stable_q + 32'd1 : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q       <= IDLE;
      timer_q       <= 32'd0;
      stable_q      <= 32'd0;
      retry_q       <= 4'd0;
      rst_request_q <= 1'b0;
      link_up_q     <= 1'b0;
      link_fail_q   <= 1'b0;
      force_prev_q  <= 1'b0;
      force_edge_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      stable_q      <= stable_d;
      retry_q       <= retry_d;
      // Outputs are decoded from the next state, so they change on the same
      // edge as the state.
      rst_request_q <= (state_d == REQ);
      link_up_q     <= (state_d == UP);
      link_fail_q   <= (state_d == FAIL);
      force_prev_q  <= force_reset;
      force_edge_q  <= force_reset & ~force_prev_q;
    end
  end

  assign rst_request = rst_request_q;
  assign link_up     = link_up_q;
  assign link_fail   = link_fail_q;
  assign retry_cnt   = retry_q;
  assign state       = state_q;

endmodule

// File: doc/gtx_link_supervisor.md
# gtx_link_supervisor

Sequences bring-up and recovery of one GTX serial link by driving the request input of the GTX reset pulse generator and supervising the transceiver status that follows. It issues reset requests, waits for the generator's start indication, then qualifies PLL lock and RX alignment for a stable window. It retries on timeout or link loss up to a bounded count before declaring failure. It sits between the fibre-link user logic and the per-link GTX reset generator.

## Interface
- REQ_CYCLES, 16: cycles `rst_request` is held high per request (≥1)
- START_TIMEOUT, 200000000: cycles allowed in WAIT_START for `gt_start`
- LINK_TIMEOUT, 10000000: cycles allowed in WAIT_LINK to achieve a stable link
- STABLE_CYCLES, 1024: consecutive cycles `pll_lock`&`rx_aligned` must be high (synchronised) to declare link up
- MAX_RETRIES, 7: retries before FAIL (1..15)

- clk  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- force_reset  input  1  user re-initialise request; rising edge acts (clk domain)
- gt_start  input  1  start indication from GTX reset generator (clk domain, no sync)
- pll_lock  input  1  GTX PLL lock, asynchronous, 2-flop synchronised
- rx_aligned  input  1  RX comma/byte alignment, asynchronous, 2-flop synchronised
- rst_request  output  1  request to GTX reset generator, registered
- link_up  output  1  link qualified and up, registered
- link_fail  output  1  retries exhausted, sticky until force_reset/rst_in
- retry_cnt  output  4  retries performed since last UP/force_reset
- state  output  3  FSM state: IDLE=0, REQ=1, WAIT_START=2, WAIT_LINK=3, UP=4, FAIL=5

## Operation
- Reset (rst_in=1 on a clk edge): state=IDLE, rst_request=0, link_up=0, link_fail=0, retry_cnt=0, timer=0, stable counter=0, sync flops=0, force_reset edge register=0.
- Single 32-bit timer, cleared on every state entry, increments while in REQ/WAIT_START/WAIT_LINK.
- IDLE: unconditional to REQ next cycle (power-up bring-up).
- REQ: rst_request=1; after exactly REQ_CYCLES cycles in REQ go WAIT_START, rst_request=0.
- WAIT_START: gt_start=1 -> WAIT_LINK. timer reaching START_TIMEOUT-1 without gt_start -> retry.
- WAIT_LINK: stable counter increments while sync'd pll_lock&rx_aligned=1, clears to 0 on any low cycle. Reaching STABLE_CYCLES -> UP. timer reaching LINK_TIMEOUT-1 first -> retry. gt_start falling -> retry.
- UP: link_up=1, retry_cnt cleared to 0 on entry. Any sync'd pll_lock or rx_aligned low, or gt_start low -> retry; link_up drops same edge.
- Retry: if retry_cnt==MAX_RETRIES go FAIL, else retry_cnt+1 and go REQ.
- FAIL: link_fail=1, rst_request=0, link_up=0; hold until force_reset edge.
- force_reset rising edge (registered edge detect) in any state: retry_cnt=0, link_fail=0, link_up=0, go REQ. Restarts REQ if already in REQ.
- Priority: rst_in > force_reset edge > timeout/loss > success. Success and timeout on same cycle: success wins.
- retry_cnt saturates at MAX_RETRIES; never wraps.

## Timing
- All outputs registered; change on the edge the state changes.
- rst_request high exactly REQ_CYCLES consecutive cycles per REQ visit, starting the cycle after REQ entry edge.
- Status sync latency 2 cycles; UP declared no earlier than STABLE_CYCLES+2 cycles after both inputs rise.
- Loss detection in UP: link_up low 3 cycles after async input falls (2 sync + 1 register).
- force_reset edge: REQ entered 2 cycles after rising edge (edge register + FSM).
- Worst-case to FAIL: (MAX_RETRIES+1)·(REQ_CYCLES+START_TIMEOUT+LINK_TIMEOUT) cycles plus transitions.

## Test plan
(REQ_CYCLES=4, START_TIMEOUT=100, LINK_TIMEOUT=200, STABLE_CYCLES=16, MAX_RETRIES=3)
- Normal bring-up: release rst_in; gt_start 20 cycles after request ends; both status high -> rst_request exactly 4 cycles, link_up rises 18 cycles after status high, retry_cnt=0.
- Start timeout: gt_start held 0 -> rst_request pulses 4 times (100-cycle spacing plus REQ), then state=FAIL, link_fail=1, retry_cnt=3.
- Unstable link: rx_aligned toggles every 10 cycles -> never UP, LINK_TIMEOUT retry, retry_cnt increments to 1.
- Loss in UP: from UP drop pll_lock -> link_up=0 within 3 cycles, new 4-cycle rst_request, retry_cnt=1, then back to UP with retry_cnt=0.
- FAIL recovery: in FAIL pulse force_reset one cycle -> link_fail=0, retry_cnt=0, state=REQ 2 cycles later.
- Reset mid-operation: assert rst_in during REQ -> next edge rst_request=0, state=IDLE, all outputs at reset values.
